// File: rtl/unified_mem_arbiter_pkg.sv
// Shared definitions for the unified memory arbiter.
// Contents: FSM state encodings, the all-lanes byte select, the default
// ack timeout and the default bus widths.
package unified_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_DATA  = 2'd1,
    ARB_FETCH = 2'd2
  } arbState_e;

  localparam logic [3:0] ArbSelAll            = 4'b1111;
  localparam int         ArbAckTimeoutDefault = 255;
  localparam int         BusAddrW             = 32;
  localparam int         BusDataW             = 32;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// External single-port memory bus.
// Signals:
//   bus_req   transaction active           (master -> slave)
//   bus_we    write enable                 (master -> slave)
//   bus_sel   byte lanes                   (master -> slave)
//   bus_addr  address                      (master -> slave)
//   bus_wdata write data                   (master -> slave)
//   bus_rdata read data, valid with ack    (slave  -> master)
//   bus_ack   transaction complete         (slave  -> master)
//   bus_err   one-cycle timeout pulse      (master -> slave/observer)
interface unified_mem_arbiter_if
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = BusAddrW,
  parameter int DATA_W = BusDataW
);
  logic              bus_req;
  logic              bus_we;
  logic [3:0]        bus_sel;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ack;
  logic              bus_err;

  modport master (
    output bus_req, bus_we, bus_sel, bus_addr, bus_wdata, bus_err,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_sel, bus_addr, bus_wdata, bus_err,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/unified_mem_arbiter_timeout_ctr.sv
// Loadable cycle counter with clear and a terminal flag.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   clr       clear count to zero (wins over load/en)
//   load      load loadVal
//   loadVal   value to load
//   en        count one cycle
//   term      count has reached LIMIT-1, i.e. the current enabled cycle
//             is the LIMIT-th one since the last clear
module unified_mem_arbiter_timeout_ctr #(
  parameter int LIMIT = 255,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] loadVal,
  input  logic         en,
  output logic         term
);
  logic [W-1:0] count;

  assign term = (count == W'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (en && !term) begin
      count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-port memory bus between the instruction-fetch
// port and the load/store port. Each pipeline step serves at most one data
// access and then one fetch; stallreq holds the pipeline until both are done.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   if_ce, if_addr      fetch request and pc
//   if_inst             fetched instruction (registered)
//   d_ce, d_we, d_sel,  data request: enable, store flag, byte lanes,
//   d_addr, d_wdata     address, store data
//   d_rdata             load data (registered)
//   stallreq            pipeline stall request
//   bus                 external memory bus (master side)
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W      = BusAddrW,
  parameter int DATA_W      = BusDataW,
  parameter int ACK_TIMEOUT = ArbAckTimeoutDefault
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_ce,
  input  logic [ADDR_W-1:0]       if_addr,
  output logic [DATA_W-1:0]       if_inst,
  input  logic                    d_ce,
  input  logic                    d_we,
  input  logic [3:0]              d_sel,
  input  logic [ADDR_W-1:0]       d_addr,
  input  logic [DATA_W-1:0]       d_wdata,
  output logic [DATA_W-1:0]       d_rdata,
  output logic                    stallreq,
  unified_mem_arbiter_if.master   bus
);
  localparam int ToW = $clog2(ACK_TIMEOUT + 1);

  arbState_e         state;
  logic              dDone;
  logic              iDone;
  logic [DATA_W-1:0] ifInst;
  logic [DATA_W-1:0] dRdata;
  logic              busErr;

  logic              dPend;
  logic              iPend;
  logic              busy;
  logic              toTerm;
  logic              done;
  logic              toFire;
  logic [DATA_W-1:0] rdVal;

  assign dPend    = d_ce & ~dDone;
  assign iPend    = if_ce & ~iDone;
  assign stallreq = dPend | iPend;
  assign busy     = (state != ARB_IDLE);

  // A timeout completes the transaction exactly like an ack, but with the
  // read data forced to zero so stale bus values never reach the pipeline.
  assign done   = busy & (bus.bus_ack | toTerm);
  assign toFire = busy & ~bus.bus_ack & toTerm;
  assign rdVal  = bus.bus_ack ? bus.bus_rdata : '0;

  assign if_inst     = ifInst;
  assign d_rdata     = dRdata;
  assign bus.bus_err = busErr;

  unified_mem_arbiter_timeout_ctr #(
    .LIMIT (ACK_TIMEOUT),
    .W     (ToW)
  ) uTimeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (~busy | done),
    .load    (1'b0),
    .loadVal ('0),
    .en      (busy & ~bus.bus_ack),
    .term    (toTerm)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ARB_IDLE;
      dDone  <= 1'b0;
      iDone  <= 1'b0;
      ifInst <= '0;
      dRdata <= '0;
      busErr <= 1'b0;
    end else begin
      busErr <= toFire;
      // Step boundary: nothing left to do, so re-arm both requesters.
      if (!stallreq) begin
        dDone <= 1'b0;
        iDone <= 1'b0;
      end
      case (state)
        ARB_IDLE: begin
          if (dPend) begin
            state <= ARB_DATA;
          end else if (iPend) begin
            state <= ARB_FETCH;
          end
        end
        ARB_DATA: begin
          if (done) begin
            if (!d_we) begin
              dRdata <= rdVal;
            end
            dDone <= 1'b1;
            state <= iPend ? ARB_FETCH : ARB_IDLE;
          end
        end
        ARB_FETCH: begin
          if (done) begin
            ifInst <= rdVal;
            iDone  <= 1'b1;
            state  <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.bus_req   = 1'b0;
    bus.bus_we    = 1'b0;
    bus.bus_sel   = 4'b0000;
    bus.bus_addr  = '0;
    bus.bus_wdata = '0;
    case (state)
      ARB_DATA: begin
        bus.bus_req   = 1'b1;
        bus.bus_we    = d_we;
        bus.bus_sel   = d_sel;
        bus.bus_addr  = d_addr;
        bus.bus_wdata = d_wdata;
      end
      ARB_FETCH: begin
        bus.bus_req  = 1'b1;
        bus.bus_sel  = ArbSelAll;
        bus.bus_addr = if_addr;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
module tb_unified_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_ce;
  logic [31:0] if_addr;
  logic [31:0] if_inst;
  logic        d_ce;
  logic        d_we;
  logic [3:0]  d_sel;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        stallreq;

  unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mb ();

  unified_mem_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .ACK_TIMEOUT (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_ce    (if_ce),
    .if_addr  (if_addr),
    .if_inst  (if_inst),
    .d_ce     (d_ce),
    .d_we     (d_we),
    .d_sel    (d_sel),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .stallreq (stallreq),
    .bus      (mb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          len;
  } busExp_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] rdata;
    int          stall;
    int          errs;
  } stepExp_t;

  busExp_t  busQ[$];
  stepExp_t stepQ[$];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Slave memory contents: two fixed words, everything else addr ^ A5A5A5A5.
  function automatic logic [31:0] memVal(input logic [31:0] a);
    if (a == 32'h0000_0004) return 32'h3C01_1234;
    if (a == 32'h0000_0100) return 32'h1234_5678;
    return a ^ 32'hA5A5_A5A5;
  endfunction

  // Slave model: acks after slvWaits wait cycles unless slvNever.
  int slvWaits  = 0;
  bit slvNever  = 1'b0;
  bit slvStray  = 1'b0;
  int slvCnt    = 0;

  initial begin
    mb.bus_ack   = 1'b0;
    mb.bus_rdata = 32'hDEAD_BEEF;
  end

  always @(negedge clk) begin
    if (slvStray) begin
      mb.bus_ack   = 1'b1;
      mb.bus_rdata = 32'hBAD0_0BAD;
    end else if (mb.bus_req) begin
      mb.bus_ack   = !slvNever && (slvCnt == slvWaits);
      mb.bus_rdata = mb.bus_ack ? memVal(mb.bus_addr) : 32'hDEAD_BEEF;
      slvCnt       = mb.bus_ack ? 0 : slvCnt + 1;
    end else begin
      mb.bus_ack   = 1'b0;
      mb.bus_rdata = 32'hDEAD_BEEF;
      slvCnt       = 0;
    end
  end

  // Bus monitor: groups consecutive identical busy cycles into one
  // transaction and compares it with the next expected transaction.
  bit      runActive = 1'b0;
  busExp_t run;

  task automatic finishRun();
    busExp_t e;
    if (busQ.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL bus_unexpected_txn actual_addr=%h required=none", run.addr);
    end else begin
      e = busQ.pop_front();
      check("bus_we",    {31'd0, run.we},  {31'd0, e.we});
      check("bus_sel",   {28'd0, run.sel}, {28'd0, e.sel});
      check("bus_addr",  run.addr,         e.addr);
      check("bus_wdata", run.wdata,        e.wdata);
      check("bus_busy_cycles", 32'(run.len), 32'(e.len));
    end
  endtask

  always @(negedge clk) begin
    if (mb.bus_req) begin
      if (runActive && run.we == mb.bus_we && run.sel == mb.bus_sel &&
          run.addr == mb.bus_addr && run.wdata == mb.bus_wdata) begin
        run.len++;
      end else begin
        if (runActive) finishRun();
        runActive = 1'b1;
        run.we    = mb.bus_we;
        run.sel   = mb.bus_sel;
        run.addr  = mb.bus_addr;
        run.wdata = mb.bus_wdata;
        run.len   = 1;
      end
    end else if (runActive) begin
      finishRun();
      runActive = 1'b0;
    end
  end

  // Step monitor: measures each stall window and checks the registered
  // results on the cycle where stallreq has dropped.
  bit stepMonEn = 1'b0;
  int stallCnt  = 0;
  int errCnt    = 0;

  always @(negedge clk) begin
    stepExp_t e;
    if (!stepMonEn) begin
      stallCnt = 0;
      errCnt   = 0;
    end else begin
      errCnt += int'(mb.bus_err);
      if (stallreq) begin
        stallCnt++;
      end else if (stallCnt > 0) begin
        if (stepQ.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL step_unexpected actual_stall=%0d required=none", stallCnt);
        end else begin
          e = stepQ.pop_front();
          check("stall_cycles", 32'(stallCnt), 32'(e.stall));
          check("if_inst",      if_inst,       e.inst);
          check("d_rdata",      d_rdata,       e.rdata);
          check("bus_err_pulses", 32'(errCnt), 32'(e.errs));
        end
        stallCnt = 0;
        errCnt   = 0;
      end
    end
  end

  task automatic pushBus(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                         input logic [31:0] wdata, input int len);
    busExp_t e;
    e.we = we; e.sel = sel; e.addr = addr; e.wdata = wdata; e.len = len;
    busQ.push_back(e);
  endtask

  task automatic pushStep(input logic [31:0] inst, input logic [31:0] rdata,
                          input int stall, input int errs);
    stepExp_t e;
    e.inst = inst; e.rdata = rdata; e.stall = stall; e.errs = errs;
    stepQ.push_back(e);
  endtask

  // Issues one step's requests, waits (bounded) for stallreq to drop,
  // then withdraws the requests and idles two cycles.
  task automatic runStep(input logic dce, input logic dwe, input logic [3:0] dsel,
                         input logic [31:0] daddr, input logic [31:0] dwdata,
                         input logic ice, input logic [31:0] iaddr,
                         input int waits, input bit never);
    bit fell;
    fell     = 1'b0;
    slvWaits = waits;
    slvNever = never;
    d_ce = dce; d_we = dwe; d_sel = dsel; d_addr = daddr; d_wdata = dwdata;
    if_ce = ice; if_addr = iaddr;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!stallreq) begin
        fell = 1'b1;
        break;
      end
    end
    check("step_completes", {31'd0, fell}, 32'd1);
    @(posedge clk);
    #1;
    d_ce = 1'b0; if_ce = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    if_ce = 1'b0; if_addr = '0;
    d_ce = 1'b0; d_we = 1'b0; d_sel = 4'h0; d_addr = '0; d_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_stallreq", {31'd0, stallreq},   32'd0);
    check("rst_bus_req",  {31'd0, mb.bus_req}, 32'd0);
    check("rst_bus_addr", mb.bus_addr,         32'd0);
    check("rst_if_inst",  if_inst,             32'd0);
    check("rst_d_rdata",  d_rdata,             32'd0);
    check("rst_bus_err",  {31'd0, mb.bus_err}, 32'd0);
    @(posedge clk);
    #1;
    stepMonEn = 1'b1;

    // Fetch only, zero-wait.
    pushBus(1'b0, 4'hF, 32'h0000_0004, 32'h0, 1);
    pushStep(32'h3C01_1234, 32'h0, 2, 0);
    runStep(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h0000_0004, 0, 1'b0);

    // No requests: bus and stall stay quiet.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_stallreq", {31'd0, stallreq},   32'd0);
      check("idle_bus_req",  {31'd0, mb.bus_req}, 32'd0);
    end
    @(posedge clk);
    #1;

    // Load plus fetch: data goes first.
    pushBus(1'b0, 4'hF, 32'h0000_0100, 32'h0, 1);
    pushBus(1'b0, 4'hF, 32'h0000_0008, 32'h0, 1);
    pushStep(32'hA5A5_A5AD, 32'h1234_5678, 3, 0);
    runStep(1'b1, 1'b0, 4'hF, 32'h0000_0100, 32'h0, 1'b1, 32'h0000_0008, 0, 1'b0);

    // Store plus fetch: d_rdata keeps the previous load value.
    pushBus(1'b1, 4'b0011, 32'h0000_0104, 32'hAABB_CCDD, 1);
    pushBus(1'b0, 4'hF,    32'h0000_000C, 32'h0, 1);
    pushStep(32'hA5A5_A5A9, 32'h1234_5678, 3, 0);
    runStep(1'b1, 1'b1, 4'b0011, 32'h0000_0104, 32'hAABB_CCDD, 1'b1, 32'h0000_000C, 0, 1'b0);

    // Fetch with 4 wait cycles.
    pushBus(1'b0, 4'hF, 32'h0000_0010, 32'h0, 5);
    pushStep(32'hA5A5_A5B5, 32'h1234_5678, 6, 0);
    runStep(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h0000_0010, 4, 1'b0);

    // Fetch that is never acked: timeout after 8 busy cycles.
    pushBus(1'b0, 4'hF, 32'h0000_0014, 32'h0, 8);
    pushStep(32'h0, 32'h1234_5678, 9, 1);
    runStep(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h0000_0014, 0, 1'b1);

    // Normal step after the timeout.
    pushBus(1'b0, 4'hF, 32'h0000_0108, 32'h0, 1);
    pushBus(1'b0, 4'hF, 32'h0000_0018, 32'h0, 1);
    pushStep(32'hA5A5_A5BD, 32'hA5A5_A4AD, 3, 0);
    runStep(1'b1, 1'b0, 4'hF, 32'h0000_0108, 32'h0, 1'b1, 32'h0000_0018, 0, 1'b0);

    // Reset in the middle of a slow load, then a stray ack.
    stepMonEn = 1'b0;
    slvWaits  = 5;
    slvNever  = 1'b0;
    pushBus(1'b0, 4'hF, 32'h0000_0200, 32'h0, 2);
    d_ce = 1'b1; d_we = 1'b0; d_sel = 4'hF; d_addr = 32'h0000_0200; d_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst  = 1'b1;
    d_ce = 1'b0;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    slvStray = 1'b1;
    @(negedge clk);
    check("rrst_bus_req",  {31'd0, mb.bus_req}, 32'd0);
    check("rrst_bus_addr", mb.bus_addr,         32'd0);
    check("rrst_stallreq", {31'd0, stallreq},   32'd0);
    check("rrst_if_inst",  if_inst,             32'd0);
    check("rrst_d_rdata",  d_rdata,             32'd0);
    check("rrst_bus_err",  {31'd0, mb.bus_err}, 32'd0);
    @(posedge clk);
    #1;
    slvStray = 1'b0;
    @(negedge clk);
    check("stray_bus_req",  {31'd0, mb.bus_req}, 32'd0);
    check("stray_stallreq", {31'd0, stallreq},   32'd0);
    check("stray_d_rdata",  d_rdata,             32'd0);
    check("stray_if_inst",  if_inst,             32'd0);
    @(posedge clk);
    #1;
    stepMonEn = 1'b1;

    // Fresh fetch after the reset.
    pushBus(1'b0, 4'hF, 32'h0000_001C, 32'h0, 1);
    pushStep(32'hA5A5_A5B9, 32'h0, 2, 0);
    runStep(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h0000_001C, 0, 1'b0);

    repeat (4) @(posedge clk);
    check("bus_queue_drained",  32'(busQ.size()),  32'd0);
    check("step_queue_drained", 32'(stepQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
